// File: rtl/mem_load_sequencer_pkg.sv
// Shared definitions for the memory load/dump path.
// Holds the sequencer state encoding and the default address/data widths
// so the load sequencer, dump counter and display path agree on them.
// No ports (package).
package mem_load_sequencer_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_load_sequencer_if.sv
// Bus bundle between a word source, the load sequencer and the memory
// write port.
//   in_valid/in_data/in_ready : valid/ready word stream into the sequencer
//   mem_we/mem_addr/mem_wdata : registered memory write port
// Modports:
//   slave  - the sequencer side (consumes the stream, drives memory)
//   master - the environment side (source + memory)
interface mem_load_sequencer_if
  import mem_load_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_load_addr_gen.sv
// Write-address pointer for the load sequencer: a loadable, enabled
// ADDR_W up-counter that wraps silently modulo 2^ADDR_W.
// Ports:
//   clk, reset : clock, synchronous active-high reset (ptr -> 0)
//   load       : load load_val into the pointer (has priority over en)
//   load_val   : value loaded on load
//   en         : advance the pointer by one
//   ptr        : current pointer value
module mem_load_addr_gen #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              en,
  output logic [ADDR_W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else if (en) begin
      ptr <= ptr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/mem_load_sequencer.sv
// Memory load sequencer: accepts words over a valid/ready stream and writes
// them to consecutive memory addresses starting at a programmable base.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   start            : begin a load (sampled only in IDLE)
//   base_addr,length : first address and word count, latched on start
//   bus (slave)      : in_valid/in_data/in_ready stream and the registered
//                      mem_we/mem_addr/mem_wdata write port
//   busy             : high while loading
//   done             : one-cycle pulse after the final write
//   count            : words accepted in the current or last load
//   checksum         : (only with MEM_LOAD_SEQUENCER_CHECKSUM_EN) modular
//                      sum of the words of the current or last load
// Optional feature macro: MEM_LOAD_SEQUENCER_CHECKSUM_EN.
module mem_load_sequencer
  import mem_load_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [ADDR_W-1:0]        length,
  mem_load_sequencer_if.slave      bus,
  output logic                     busy,
  output logic                     done,
`ifdef MEM_LOAD_SEQUENCER_CHECKSUM_EN
  output logic [DATA_W-1:0]        checksum,
`endif
  output logic [ADDR_W-1:0]        count
);

  state_t            state;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W-1:0] ptr;
  logic              accept_start;
  logic              xfer;

  // in_ready is registered high exactly while in LOAD, so it doubles as
  // the state qualifier for a transfer.
  assign accept_start = (state == ST_IDLE) && start;
  assign xfer         = bus.in_valid && bus.in_ready;

  mem_load_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (accept_start),
    .load_val (base_addr),
    .en       (xfer),
    .ptr      (ptr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      remaining     <= '0;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      count         <= '0;
    end else begin
      bus.mem_we <= xfer;
      done       <= 1'b0;

      if (xfer) begin
        bus.mem_addr  <= ptr;
        bus.mem_wdata <= bus.in_data;
        count         <= count + ADDR_W'(1);
        remaining     <= remaining - ADDR_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            remaining <= length;
            count     <= '0;
            if (length == '0) begin
              state <= ST_FIN;
            end else begin
              state        <= ST_LOAD;
              bus.in_ready <= 1'b1;
              busy         <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          // Last word: drop ready on the same edge that registers its write.
          if (xfer && remaining == ADDR_W'(1)) begin
            state        <= ST_FIN;
            bus.in_ready <= 1'b0;
            busy         <= 1'b0;
          end
        end
        ST_FIN: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_LOAD_SEQUENCER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
    end else if (accept_start) begin
      checksum <= '0;
    end else if (xfer) begin
      checksum <= checksum + bus.in_data;
    end
  end
`endif

endmodule

// File: tb/tb_mem_load_sequencer.sv
// Directed testbench for mem_load_sequencer: a cycle-by-cycle vector table
// for the basic, stalling and zero-length loads, followed by hand-written
// sequences for address wrap, mid-load start/reset, and the optional
// checksum (MEM_LOAD_SEQUENCER_CHECKSUM_EN).
module tb_mem_load_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic [15:0] count;
`ifdef MEM_LOAD_SEQUENCER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int tests = 0;
  int fails = 0;

  mem_load_sequencer_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_load_sequencer #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
`ifdef MEM_LOAD_SEQUENCER_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        st;
    logic [15:0] base;
    logic [15:0] len;
    logic        vld;
    logic [15:0] data;
    logic        e_rdy;
    logic        e_we;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
    logic        e_busy;
    logic        e_done;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 25;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive inputs just after an edge, advance one clock, sample 1ns after it.
  task automatic step(input logic r, input logic s, input logic [15:0] b,
                      input logic [15:0] l, input logic v, input logic [15:0] d);
    reset        = r;
    start        = s;
    base_addr    = b;
    length       = l;
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic rdy, input logic we,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic bsy, input logic dn, input logic [15:0] cnt);
    chk({tag, ".in_ready"},  bus.in_ready,  rdy);
    chk({tag, ".mem_we"},    bus.mem_we,    we);
    chk({tag, ".mem_addr"},  bus.mem_addr,  addr);
    chk({tag, ".mem_wdata"}, bus.mem_wdata, wdata);
    chk({tag, ".busy"},      busy,          bsy);
    chk({tag, ".done"},      done,          dn);
    chk({tag, ".count"},     count,         cnt);
  endtask

  initial begin
    //          rst st base     len      vld data      rdy we addr     wdata    bsy dn cnt
    // reset state
    vec[0]  = '{1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'd0};
    // basic load: base 0x10, 4 words back-to-back
    vec[1]  = '{0, 1, 16'h0010, 16'h0004, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 1, 0, 16'd0};
    vec[2]  = '{0, 0, 16'h0000, 16'h0000, 1, 16'h00A1, 1, 1, 16'h0010, 16'h00A1, 1, 0, 16'd1};
    vec[3]  = '{0, 0, 16'h0000, 16'h0000, 1, 16'h00A2, 1, 1, 16'h0011, 16'h00A2, 1, 0, 16'd2};
    vec[4]  = '{0, 0, 16'h0000, 16'h0000, 1, 16'h00A3, 1, 1, 16'h0012, 16'h00A3, 1, 0, 16'd3};
    vec[5]  = '{0, 0, 16'h0000, 16'h0000, 1, 16'h00A4, 0, 1, 16'h0013, 16'h00A4, 0, 0, 16'd4};
    vec[6]  = '{0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0013, 16'h00A4, 0, 1, 16'd4};
    vec[7]  = '{0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0013, 16'h00A4, 0, 0, 16'd4};
    // stalling source: in_valid 1,0,0,1,...
    vec[8]  = '{0, 1, 16'h0010, 16'h0004, 0, 16'h0000, 1, 0, 16'h0013, 16'h00A4, 1, 0, 16'd0};
    vec[9]  = '{0, 0, 16'h0000, 16'h0000, 1, 16'h00B1, 1, 1, 16'h0010, 16'h00B1, 1, 0, 16'd1};
    vec[10] = '{0, 0, 16'h0000, 16'h0000, 0, 16'hDEAD, 1, 0, 16'h0010, 16'h00B1, 1, 0, 16'd1};
    vec[11] = '{0, 0, 16'h0000, 16'h0000, 0, 16'hDEAD, 1, 0, 16'h0010, 16'h00B1, 1, 0, 16'd1};
    vec[12] = '{0, 0, 16'h0000, 16'h0000, 1, 16'h00B2, 1, 1, 16'h0011, 16'h00B2, 1, 0, 16'd2};
    vec[13] = '{0, 0, 16'h0000, 16'h0000, 0, 16'hDEAD, 1, 0, 16'h0011, 16'h00B2, 1, 0, 16'd2};
    vec[14] = '{0, 0, 16'h0000, 16'h0000, 0, 16'hDEAD, 1, 0, 16'h0011, 16'h00B2, 1, 0, 16'd2};
    vec[15] = '{0, 0, 16'h0000, 16'h0000, 1, 16'h00B3, 1, 1, 16'h0012, 16'h00B3, 1, 0, 16'd3};
    vec[16] = '{0, 0, 16'h0000, 16'h0000, 0, 16'hDEAD, 1, 0, 16'h0012, 16'h00B3, 1, 0, 16'd3};
    vec[17] = '{0, 0, 16'h0000, 16'h0000, 0, 16'hDEAD, 1, 0, 16'h0012, 16'h00B3, 1, 0, 16'd3};
    vec[18] = '{0, 0, 16'h0000, 16'h0000, 1, 16'h00B4, 0, 1, 16'h0013, 16'h00B4, 0, 0, 16'd4};
    // valid with ready low is not a transfer
    vec[19] = '{0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF, 0, 0, 16'h0013, 16'h00B4, 0, 1, 16'd4};
    vec[20] = '{0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0013, 16'h00B4, 0, 0, 16'd4};
    // zero length: done two cycles after start; start during FIN ignored
    vec[21] = '{0, 1, 16'h0050, 16'h0000, 0, 16'h0000, 0, 0, 16'h0013, 16'h00B4, 0, 0, 16'd0};
    vec[22] = '{0, 1, 16'h0060, 16'h0002, 0, 16'h0000, 0, 0, 16'h0013, 16'h00B4, 0, 1, 16'd0};
    vec[23] = '{0, 0, 16'h0000, 16'h0000, 1, 16'h1234, 0, 0, 16'h0013, 16'h00B4, 0, 0, 16'd0};
    vec[24] = '{0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0013, 16'h00B4, 0, 0, 16'd0};

    step(1, 0, 16'h0, 16'h0, 0, 16'h0);

    for (int i = 0; i < NV; i++) begin
      step(vec[i].rst, vec[i].st, vec[i].base, vec[i].len, vec[i].vld, vec[i].data);
      chk_out($sformatf("v%0d", i), vec[i].e_rdy, vec[i].e_we, vec[i].e_addr,
              vec[i].e_wdata, vec[i].e_busy, vec[i].e_done, vec[i].e_cnt);
    end

    // Address wrap: 0xFFFE, 0xFFFF, 0x0000
    step(0, 1, 16'hFFFE, 16'd3, 0, 16'h0);
    chk_out("wrap.start", 1, 0, 16'h0013, 16'h00B4, 1, 0, 16'd0);
    step(0, 0, 16'h0, 16'h0, 1, 16'h00C1);
    chk_out("wrap.w0", 1, 1, 16'hFFFE, 16'h00C1, 1, 0, 16'd1);
    step(0, 0, 16'h0, 16'h0, 1, 16'h00C2);
    chk_out("wrap.w1", 1, 1, 16'hFFFF, 16'h00C2, 1, 0, 16'd2);
    step(0, 0, 16'h0, 16'h0, 1, 16'h00C3);
    chk_out("wrap.w2", 0, 1, 16'h0000, 16'h00C3, 0, 0, 16'd3);
    step(0, 0, 16'h0, 16'h0, 0, 16'h0);
    chk_out("wrap.done", 0, 0, 16'h0000, 16'h00C3, 0, 1, 16'd3);

    // Mid-load start ignored, then reset after 2 of 5 words
    step(0, 0, 16'h0, 16'h0, 0, 16'h0);
    step(0, 1, 16'h0200, 16'd5, 0, 16'h0);
    chk_out("abort.start", 1, 0, 16'h0000, 16'h00C3, 1, 0, 16'd0);
    step(0, 0, 16'h0, 16'h0, 1, 16'h00D1);
    chk_out("abort.w0", 1, 1, 16'h0200, 16'h00D1, 1, 0, 16'd1);
    step(0, 1, 16'h0300, 16'd9, 1, 16'h00D2);
    chk_out("abort.w1_restart_ignored", 1, 1, 16'h0201, 16'h00D2, 1, 0, 16'd2);
    step(1, 0, 16'h0, 16'h0, 1, 16'h00D3);
    chk_out("abort.reset", 0, 0, 16'h0000, 16'h0000, 0, 0, 16'd0);
`ifdef MEM_LOAD_SEQUENCER_CHECKSUM_EN
    chk("abort.reset.checksum", checksum, 16'h0000);
`endif
    step(0, 0, 16'h0, 16'h0, 1, 16'h00D4);
    chk_out("abort.after1", 0, 0, 16'h0000, 16'h0000, 0, 0, 16'd0);
    step(0, 0, 16'h0, 16'h0, 1, 16'h00D5);
    chk_out("abort.after2", 0, 0, 16'h0000, 16'h0000, 0, 0, 16'd0);
    step(0, 1, 16'h0100, 16'd1, 0, 16'h0);
    chk_out("reload.start", 1, 0, 16'h0000, 16'h0000, 1, 0, 16'd0);
    step(0, 0, 16'h0, 16'h0, 1, 16'h00E1);
    chk_out("reload.w0", 0, 1, 16'h0100, 16'h00E1, 0, 0, 16'd1);
    step(0, 0, 16'h0, 16'h0, 0, 16'h0);
    chk_out("reload.done", 0, 0, 16'h0100, 16'h00E1, 0, 1, 16'd1);

`ifdef MEM_LOAD_SEQUENCER_CHECKSUM_EN
    // Checksum wraps modulo 2^16: 0xFFFF + 0x0002 = 0x0001
    step(0, 0, 16'h0, 16'h0, 0, 16'h0);
    step(0, 1, 16'h0400, 16'd2, 0, 16'h0);
    chk("csum.cleared", checksum, 16'h0000);
    step(0, 0, 16'h0, 16'h0, 1, 16'hFFFF);
    step(0, 0, 16'h0, 16'h0, 1, 16'h0002);
    chk("csum.last_we", bus.mem_we, 1'b1);
    step(0, 0, 16'h0, 16'h0, 0, 16'h0);
    chk("csum.done", done, 1'b1);
    chk("csum.value", checksum, 16'h0001);
    step(0, 0, 16'h0, 16'h0, 1, 16'h7777);
    chk("csum.stable", checksum, 16'h0001);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
